fir_da_sequencer: RTL and testbench

Frame controller for the 4-tap, 16-bit distributed-arithmetic FIR core. It accepts parallel 16-bit samples on a valid/ready stream and drives the core's bit-serial input LSB-first, along with the 4-bit bit-index counter. It captures the core's 33-bit result once per 16-cycle frame and presents it on a valid/ready output stream. The core's delay line shifts every clock, so once running, the sequencer keeps frames back-to-back and inserts zero samples on underrun.

---
 rtl/fir_da_sequencer.sv | 143 ++++++++++++++
 tb/tb_fir_da_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_da_sequencer.sv
// Frame controller for the 4-tap distributed-arithmetic FIR core: serialises
// parallel samples LSB-first, drives the bit index and captures one result per frame.
module fir_da_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned OUT_W  = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              fir_xn_b,
  output logic [CNT_W-1:0]  fir_counter,
  input  logic [OUT_W-1:0]  fir_yn,
  output logic              underrun,
  output logic              overflow,
  input  logic              clr_status
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                cap_pend_q, cap_pend_d;
  logic                m_valid_q, m_valid_d;
  logic [OUT_W-1:0]    m_data_q, m_data_d;
  logic                underrun_q, underrun_d;
  logic                overflow_q, overflow_d;

  logic                wrap_c;
  logic                load_now_c;
  logic                underrun_set_c;
  logic                overflow_set_c;
  logic                s_ready_c;
  logic                s_hs_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= '0;
      cap_pend_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      cap_pend_q  <= cap_pend_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
    end
  end

  // Frame sequencing, hold buffer, result capture and status flags
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tx_d           = tx_q;
    load_now_c     = 1'b0;
    underrun_set_c = 1'b0;
    overflow_set_c = 1'b0;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    wrap_c         = (cnt_q == LAST_BIT);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable && hold_full_q) begin
          state_d    = RUN;
          tx_d       = hold_q;
          load_now_c = 1'b1;
        end
      end
      RUN: begin
        cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
        // The core's delay line never stops, so an empty buffer sends a zero frame
        if (wrap_c) begin
          if (!enable) begin
            state_d = IDLE;
          end else if (hold_full_q) begin
            tx_d       = hold_q;
            load_now_c = 1'b1;
          end else begin
            tx_d           = '0;
            underrun_set_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_c   = !hold_full_q || load_now_c;
    s_hs_c      = s_valid && s_ready_c;
    hold_d      = s_hs_c ? s_data : hold_q;
    hold_full_d = s_hs_c ? 1'b1 : (load_now_c ? 1'b0 : hold_full_q);

    cap_pend_d = (state_q == RUN) && wrap_c;

    if (cap_pend_q) begin
      if (m_valid_q && !m_ready) begin
        overflow_set_c = 1'b1;
      end else begin
        m_data_d  = fir_yn;
        m_valid_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    underrun_d = underrun_set_c ? 1'b1 : (clr_status ? 1'b0 : underrun_q);
    overflow_d = overflow_set_c ? 1'b1 : (clr_status ? 1'b0 : overflow_q);
  end

  assign s_ready     = s_ready_c;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign fir_counter = cnt_q;
  assign fir_xn_b    = (state_q == RUN) ? tx_q[cnt_q] : 1'b0;
  assign underrun    = underrun_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fir_da_sequencer.sv
// Bench for fir_da_sequencer: table-driven sample stream plus directed corner
// sequences, with a serial-frame monitor and a result scoreboard.
module tb_fir_da_sequencer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OUT_W  = 33;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic              fir_xn_b;
  logic [CNT_W-1:0]  fir_counter;
  logic [OUT_W-1:0]  fir_yn;
  logic              underrun;
  logic              overflow;
  logic              clr_status;

  fir_da_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fir_xn_b(fir_xn_b), .fir_counter(fir_counter), .fir_yn(fir_yn),
    .underrun(underrun), .overflow(overflow), .clr_status(clr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [OUT_W-1:0]  yn;
    logic              exp_rdy;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [OUT_W-1:0]  yn;
    time               t_acc;
  } tx_t;

  tx_t              tx_q[$];
  logic [OUT_W-1:0] res_q[$];
  logic [OUT_W-1:0] cur_yn;
  logic             exp_ovf;
  int               n_chk;
  int               n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and return just after the edge that accepted it
  task automatic send(input logic [DATA_W-1:0] d, input logic [OUT_W-1:0] y);
    int k;
    s_valid = 1'b1;
    s_data  = d;
    cur_yn  = y;
    k = 0;
    @(negedge clk);
    while (!s_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("s_ready_wait", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Monitor: rebuilds each serial frame, drives fir_yn in the capture cycle,
  // and scoreboards the output register including drop-on-stall.
  logic [CNT_W-1:0]  mon_prev;
  logic [CNT_W-1:0]  mon_cnt;
  logic              mon_running;
  logic              mon_cap_due;
  logic [OUT_W-1:0]  mon_cap_yn;
  logic [DATA_W-1:0] mon_bits;
  logic [DATA_W-1:0] mon_exp_w;
  time               mon_start_t;
  tx_t               mon_t;
  int                mon_nz;

  initial begin
    fir_yn      = '0;
    exp_ovf     = 1'b0;
    mon_prev    = '0;
    mon_running = 1'b0;
    mon_cap_due = 1'b0;
    mon_cap_yn  = '0;
    mon_bits    = '0;
    mon_start_t = 0;
    mon_nz      = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        tx_q.delete();
        res_q.delete();
        mon_prev    = '0;
        mon_running = 1'b0;
        mon_cap_due = 1'b0;
        exp_ovf     = 1'b0;
        fir_yn      = 33'($urandom);
        continue;
      end
      chk("m_valid", m_valid, res_q.size() > 0);
      if (m_valid && res_q.size() > 0) begin
        chk("m_data", m_data, res_q[0]);
        if (m_ready) void'(res_q.pop_front());
      end
      if (mon_cap_due) begin
        fir_yn = mon_cap_yn;
        if (res_q.size() > 0) exp_ovf = 1'b1;
        else res_q.push_back(mon_cap_yn);
        mon_cap_due = 1'b0;
      end else begin
        fir_yn = {1'b1, 32'($urandom)};
      end
      if (s_valid && s_ready) tx_q.push_back('{s_data, cur_yn, $time + 5});
      mon_cnt = fir_counter;
      if (mon_running) begin
        chk("cnt_seq", mon_cnt, 4'(mon_prev + 1));
      end else if (mon_cnt != 0) begin
        chk("cnt_start", {mon_prev, mon_cnt}, {4'd0, 4'd1});
        mon_running = 1'b1;
      end
      if (mon_cnt == 0) begin
        mon_start_t = $time;
        mon_bits    = '0;
      end
      mon_bits[mon_cnt] = fir_xn_b;
      if (mon_cnt == 4'(DATA_W - 1)) begin
        // A sample belongs to this frame only if accepted before its load edge
        if (tx_q.size() > 0 && tx_q[0].t_acc < mon_start_t - 5) begin
          mon_t      = tx_q.pop_front();
          mon_exp_w  = mon_t.data;
          mon_cap_yn = mon_t.yn;
        end else begin
          mon_exp_w  = '0;
          mon_cap_yn = 33'h0_0DEA_D000 + 33'(mon_nz);
          mon_nz++;
        end
        chk("tx_word", mon_bits, mon_exp_w);
        mon_cap_due = 1'b1;
        if (!enable) mon_running = 1'b0;
      end
      mon_prev = mon_cnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[6];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{16'h0001, 33'h0_1234_5678, 1'b1};
    vecs[1] = '{16'h8000, 33'h1_8000_0001, 1'b0};
    vecs[2] = '{16'hA5A5, 33'h0_A5A5_A5A5, 1'b0};
    vecs[3] = '{16'h5A5A, 33'h1_5A5A_0000, 1'b0};
    vecs[4] = '{16'hFFFF, 33'h1_FFFF_FFFF, 1'b0};
    vecs[5] = '{16'h7FFF, 33'h0_0000_7FFF, 1'b0};

    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    m_ready = 1'b1; clr_status = 1'b0; cur_yn = '0;
    repeat (3) tick();
    chk("rst_counter", fir_counter, 0);
    chk("rst_xn_b", fir_xn_b, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_s_ready", s_ready, 1);
    reset = 1'b0;
    enable = 1'b1;
    tick();
    chk("idle_empty_cnt", fir_counter, 0);

    // Table: back-to-back sample stream
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data, vecs[i].yn);
      chk("s_ready_after_accept", s_ready, vecs[i].exp_rdy);
      if (i == 0) begin
        chk("idle_before_load_xn", fir_xn_b, 0);
        tick();
        chk("first_cnt0", fir_counter, 0);
        chk("first_bit0", fir_xn_b, 1);
        tick();
        chk("first_cnt1", fir_counter, 1);
        chk("first_bit1", fir_xn_b, 0);
      end
    end

    // Underrun: starve the stream, then clear the sticky flag
    repeat (48) tick();
    chk("underrun_set", underrun, 1);
    chk("overflow_clear_so_far", overflow, exp_ovf);
    send(16'h1357, 33'h0_1357_1357);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("underrun_clr", underrun, 0);

    // Overflow: stall the output across several captures, then stop and drain
    m_ready = 1'b0;
    send(16'hC3C3, 33'h1_C3C3_0001);
    send(16'h0F0F, 33'h0_0F0F_0002);
    repeat (16) tick();
    enable = 1'b0;
    repeat (40) tick();
    chk("overflow_model", overflow, exp_ovf);
    chk("overflow_set", overflow, 1);
    chk("held_m_valid", m_valid, 1);
    chk("idle_cnt_after_stop", fir_counter, 0);
    m_ready = 1'b1;
    tick();
    chk("drained_m_valid", m_valid, 0);

    // enable dropped mid-frame: frame completes and its result is still captured
    enable = 1'b1;
    send(16'h6E6E, 33'h0_6E6E_6E6E);
    for (int k = 0; k < 40 && fir_counter != 4'd5; k++) tick();
    chk("reach_cnt5", fir_counter, 5);
    enable = 1'b0;
    repeat (10) tick();
    chk("frame_completes", fir_counter, 15);
    tick();
    chk("back_to_idle_cnt", fir_counter, 0);
    chk("pre_capture_m_valid", m_valid, 0);
    tick();
    chk("final_capture_valid", m_valid, 1);
    chk("final_capture_data", m_data, 33'h0_6E6E_6E6E);
    tick();
    chk("final_capture_taken", m_valid, 0);
    for (int k = 0; k < 4; k++) begin
      chk("idle_cnt_hold", fir_counter, 0);
      chk("idle_xn_b", fir_xn_b, 0);
      tick();
    end

    // Reset mid-frame with a result pending
    enable = 1'b1;
    m_ready = 1'b0;
    send(16'h1111, 33'h0_1111_0000);
    send(16'h2222, 33'h0_2222_0000);
    send(16'h3333, 33'h0_3333_0000);
    for (int k = 0; k < 40 && fir_counter != 4'd9; k++) tick();
    chk("reach_cnt9", fir_counter, 9);
    chk("pending_before_rst", m_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_counter", fir_counter, 0);
    chk("mrst_xn_b", fir_xn_b, 0);
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_m_data", m_data, 0);
    chk("mrst_underrun", underrun, 0);
    chk("mrst_overflow", overflow, 0);
    chk("mrst_s_ready", s_ready, 1);
    repeat (20) tick();
    chk("mrst_no_capture", m_valid, 0);
    chk("mrst_stays_idle", fir_counter, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
